// File: rtl/input_conditioner.sv
// ============================================================================
// input_conditioner: two-flop sync, per-bit debounce, rise/fall/changed pulses;
// macro INPUT_COND_TOGGLE_EN adds per-bit toggle outputs.   Revision: 1.0
// ============================================================================
`default_nettype none

module input_conditioner #(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             CLOCK_50_I,
  input  logic             RESETN_I,
  input  logic [WIDTH-1:0] RAW_I,
  output logic [WIDTH-1:0] CLEAN_O,
  output logic [WIDTH-1:0] RISE_O,
  output logic [WIDTH-1:0] FALL_O,
  output logic             CHANGED_O,
  output logic [WIDTH-1:0] TOGGLE_O
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= RAW_I;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [CNT_W-1:0] cnt;
      logic             pending;

      assign pending   = (sync2[i] != clean[i]);
      assign accept[i] = pending && (cnt == CNT_LAST);

      // Counter only runs while the synchronised level disagrees with clean.
      always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
          cnt <= '0;
        end else if (!pending || (cnt == CNT_LAST)) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

  // accept is only set on pending bits, so flipping clean loads sync2.
  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      clean   <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      clean   <= clean ^ accept;
      rise    <= accept & sync2;
      fall    <= accept & ~sync2;
      changed <= |accept;
    end
  end

  assign CLEAN_O   = clean;
  assign RISE_O    = rise;
  assign FALL_O    = fall;
  assign CHANGED_O = changed;

`ifdef INPUT_COND_TOGGLE_EN
  logic [WIDTH-1:0] toggle;

  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      toggle <= '0;
    end else begin
      toggle <= toggle ^ rise;
    end
  end

  assign TOGGLE_O = toggle;
`else
  assign TOGGLE_O = '0;
`endif

endmodule

`default_nettype wire
